// File: rtl/latch_bank_db.sv
// Multi-channel output register bank with per-channel shadow copies, pass-through or
// atomic double-buffered commit, and an optional auto-commit countdown after the last write.
module latch_bank_db #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int SEL_W       = 2,
    parameter int AUTO_COMMIT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [SEL_W-1:0]          wr_sel,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      mode,
    input  logic                      commit,
    input  logic                      freeze,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       dirty,
    output logic                      commit_done,
    output logic                      wr_err
);

    localparam int             CNT_W    = (AUTO_COMMIT > 0) ? $clog2(AUTO_COMMIT + 1) : 1;
    localparam logic [SEL_W:0] CH_LIM_C = (SEL_W + 1)'(CHANNELS);
    localparam logic [CNT_W-1:0] CNT_LOAD_C = CNT_W'(AUTO_COMMIT);

    logic [CHANNELS*WIDTH-1:0] shadow_r;
    logic [CHANNELS*WIDTH-1:0] q_r;
    logic [CHANNELS-1:0]       dirty_r;
    logic                      commit_done_r;
    logic                      wr_err_r;
    logic [CNT_W-1:0]          cnt_r;

    logic                      wr_ok_s;
    logic                      wr_bad_s;
    logic [CHANNELS-1:0]       wr_mask_s;
    logic [CHANNELS*WIDTH-1:0] shadow_nxt_s;
    logic [CHANNELS*WIDTH-1:0] q_nxt_s;
    logic [CHANNELS-1:0]       dirty_nxt_s;
    logic [CNT_W-1:0]          cnt_nxt_s;
    logic                      pass_s;
    logic                      auto_fire_s;
    logic                      commit_ev_s;

    // Next-state decode for shadows, outputs, dirty flags and the auto-commit counter
    always_comb begin
        wr_ok_s      = wr_en && ({1'b0, wr_sel} < CH_LIM_C);
        wr_bad_s     = wr_en && !({1'b0, wr_sel} < CH_LIM_C);
        shadow_nxt_s = shadow_r;
        wr_mask_s    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_ok_s && ({1'b0, wr_sel} == (SEL_W + 1)'(i))) begin
                shadow_nxt_s[i*WIDTH +: WIDTH] = wr_data;
                wr_mask_s[i]                   = 1'b1;
            end else begin
                wr_mask_s[i]                   = 1'b0;
            end
        end

        pass_s = !mode && !freeze;

        if (AUTO_COMMIT > 0) begin
            auto_fire_s = (cnt_r == CNT_W'(1)) && !freeze;
        end else begin
            auto_fire_s = 1'b0;
        end
        commit_ev_s = !freeze && (commit || auto_fire_s);

        // A commit copies the post-write shadows, so a same-cycle write is committed too
        q_nxt_s = q_r;
        if (commit_ev_s) begin
            q_nxt_s = shadow_nxt_s;
        end else if (pass_s) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_mask_s[i]) begin
                    q_nxt_s[i*WIDTH +: WIDTH] = wr_data;
                end else begin
                    q_nxt_s[i*WIDTH +: WIDTH] = q_r[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            q_nxt_s = q_r;
        end

        dirty_nxt_s = dirty_r;
        if (commit_ev_s) begin
            dirty_nxt_s = '0;
        end else if (pass_s) begin
            dirty_nxt_s = dirty_r;
        end else begin
            dirty_nxt_s = dirty_r | wr_mask_s;
        end

        cnt_nxt_s = cnt_r;
        if (commit_ev_s) begin
            cnt_nxt_s = '0;
        end else if ((AUTO_COMMIT > 0) && wr_ok_s && mode) begin
            cnt_nxt_s = CNT_LOAD_C;
        end else if ((cnt_r != '0) && !freeze) begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r      <= '0;
            q_r           <= '0;
            dirty_r       <= '0;
            commit_done_r <= 1'b0;
            wr_err_r      <= 1'b0;
            cnt_r         <= '0;
        end else begin
            shadow_r      <= shadow_nxt_s;
            q_r           <= q_nxt_s;
            dirty_r       <= dirty_nxt_s;
            commit_done_r <= commit_ev_s;
            wr_err_r      <= wr_bad_s;
            cnt_r         <= cnt_nxt_s;
        end
    end

    assign q           = q_r;
    assign dirty       = dirty_r;
    assign commit_done = commit_done_r;
    assign wr_err      = wr_err_r;

endmodule

// File: tb/tb_latch_bank_db.sv
// Directed bench: dut_a is the 4-channel bank without auto-commit, dut_b is a
// 3-channel bank with AUTO_COMMIT=3 (covers out-of-range selects and the countdown).
module tb_latch_bank_db;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_wr_en, a_mode, a_commit, a_freeze;
    logic [1:0]  a_wr_sel;
    logic [7:0]  a_wr_data;
    logic [31:0] a_q;
    logic [3:0]  a_dirty;
    logic        a_done, a_err;

    logic        b_wr_en, b_mode, b_commit, b_freeze;
    logic [1:0]  b_wr_sel;
    logic [7:0]  b_wr_data;
    logic [23:0] b_q;
    logic [2:0]  b_dirty;
    logic        b_done, b_err;

    int pass_cnt = 0;
    int total    = 0;

    latch_bank_db #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .AUTO_COMMIT(0)) dut_a (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_sel(a_wr_sel), .wr_data(a_wr_data),
        .mode(a_mode), .commit(a_commit), .freeze(a_freeze),
        .q(a_q), .dirty(a_dirty), .commit_done(a_done), .wr_err(a_err)
    );

    latch_bank_db #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .AUTO_COMMIT(3)) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
        .mode(b_mode), .commit(b_commit), .freeze(b_freeze),
        .q(b_q), .dirty(b_dirty), .commit_done(b_done), .wr_err(b_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wr(input logic [1:0] sel, input logic [7:0] d);
        a_wr_en = 1'b1; a_wr_sel = sel; a_wr_data = d;
    endtask

    task automatic b_wr(input logic [1:0] sel, input logic [7:0] d);
        b_wr_en = 1'b1; b_wr_sel = sel; b_wr_data = d;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a_wr_en = 1'b0; a_wr_sel = 2'd0; a_wr_data = 8'h00;
        a_mode = 1'b0; a_commit = 1'b0; a_freeze = 1'b0;
        b_wr_en = 1'b0; b_wr_sel = 2'd0; b_wr_data = 8'h00;
        b_mode = 1'b0; b_commit = 1'b0; b_freeze = 1'b0;
        #12 rst = 1'b0;
        @(negedge clk);
        chk("reset_q",     a_q,     32'h0);
        chk("reset_dirty", {28'h0, a_dirty}, 32'h0);
        chk("reset_done",  {31'h0, a_done},  32'h0);
        chk("reset_err",   {31'h0, a_err},   32'h0);
        tick();

        // pass-through write
        a_mode = 1'b0; a_wr(2'd2, 8'hA5);
        tick();
        a_wr_en = 1'b0;
        chk("pass_q",     a_q, 32'h00A5_0000);
        chk("pass_dirty", {28'h0, a_dirty}, 32'h0);

        // async reset mid-cycle, sampled before any further edge
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q",     a_q, 32'h0);
        chk("async_rst_dirty", {28'h0, a_dirty}, 32'h0);
        rst = 1'b0;
        tick();

        // double buffer
        a_mode = 1'b1; a_wr(2'd0, 8'h11);
        tick();
        a_wr(2'd3, 8'h44);
        tick();
        a_wr_en = 1'b0;
        chk("db_q_held", a_q, 32'h0);
        chk("db_dirty",  {28'h0, a_dirty}, 32'h9);
        chk("db_nodone", {31'h0, a_done},  32'h0);
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        chk("commit_q",     a_q, 32'h4400_0011);
        chk("commit_dirty", {28'h0, a_dirty}, 32'h0);
        chk("commit_done",  {31'h0, a_done},  32'h1);
        tick();
        chk("done_1cycle",  {31'h0, a_done},  32'h0);

        // write and commit together
        a_wr(2'd1, 8'h22);
        tick();
        chk("wc_dirty_pre", {28'h0, a_dirty}, 32'h2);
        a_wr(2'd1, 8'h33); a_commit = 1'b1;
        tick();
        a_wr_en = 1'b0; a_commit = 1'b0;
        chk("wc_q",     a_q, 32'h4400_3311);
        chk("wc_dirty", {28'h0, a_dirty}, 32'h0);
        chk("wc_done",  {31'h0, a_done},  32'h1);

        // freeze blocks pass-through and commit
        a_freeze = 1'b1; a_mode = 1'b0; a_wr(2'd0, 8'h7F);
        tick();
        a_wr_en = 1'b0;
        chk("frz_q",     a_q, 32'h4400_3311);
        chk("frz_dirty", {28'h0, a_dirty}, 32'h1);
        a_commit = 1'b1;
        tick();
        chk("frz_commit_q",     a_q, 32'h4400_3311);
        chk("frz_commit_dirty", {28'h0, a_dirty}, 32'h1);
        chk("frz_commit_done",  {31'h0, a_done},  32'h0);
        a_freeze = 1'b0;
        tick();
        a_commit = 1'b0;
        chk("unfrz_q",    a_q, 32'h4400_337F);
        chk("unfrz_done", {31'h0, a_done}, 32'h1);

        // dirty survives a 1->0 mode switch
        a_mode = 1'b1; a_wr(2'd3, 8'h99);
        tick();
        a_wr_en = 1'b0; a_mode = 1'b0;
        tick();
        chk("mode_sw_dirty", {28'h0, a_dirty}, 32'h8);
        chk("mode_sw_q",     a_q, 32'h4400_337F);
        a_wr(2'd2, 8'hBB);
        tick();
        a_wr_en = 1'b0;
        chk("mode_sw_pass_q",     a_q, 32'h44BB_337F);
        chk("mode_sw_pass_dirty", {28'h0, a_dirty}, 32'h8);
        a_commit = 1'b1;
        tick();
        chk("mode_sw_commit_q", a_q, 32'h99BB_337F);
        chk("mode_sw_commit_dirty", {28'h0, a_dirty}, 32'h0);
        tick();
        a_commit = 1'b0;
        chk("empty_commit_done", {31'h0, a_done}, 32'h1);
        chk("empty_commit_q",    a_q, 32'h99BB_337F);

        // out-of-range select on the 3-channel bank
        b_mode = 1'b0; b_wr(2'd0, 8'h12);
        tick();
        chk("b_pass_q", {8'h0, b_q}, 32'h0000_0012);
        b_wr(2'd3, 8'hFF);
        tick();
        b_wr_en = 1'b0;
        chk("err_pulse", {31'h0, b_err}, 32'h1);
        chk("err_q",     {8'h0, b_q}, 32'h0000_0012);
        chk("err_dirty", {29'h0, b_dirty}, 32'h0);
        tick();
        chk("err_clear", {31'h0, b_err}, 32'h0);
        b_mode = 1'b1; b_wr(2'd3, 8'hEE);
        tick();
        b_wr_en = 1'b0;
        chk("err_db_pulse", {31'h0, b_err}, 32'h1);
        chk("err_db_dirty", {29'h0, b_dirty}, 32'h0);
        tick(); tick(); tick();
        chk("err_no_auto", {31'h0, b_done}, 32'h0);

        // auto-commit: write at E, q updates at E+3
        b_wr(2'd2, 8'h5A);
        tick();
        b_wr_en = 1'b0;
        chk("auto_e0_q",     {8'h0, b_q}, 32'h0000_0012);
        chk("auto_e0_dirty", {29'h0, b_dirty}, 32'h4);
        tick();
        chk("auto_e1_q", {8'h0, b_q}, 32'h0000_0012);
        tick();
        chk("auto_e2_q", {8'h0, b_q}, 32'h0000_0012);
        tick();
        chk("auto_e3_q",     {8'h0, b_q}, 32'h005A_0012);
        chk("auto_e3_done",  {31'h0, b_done}, 32'h1);
        chk("auto_e3_dirty", {29'h0, b_dirty}, 32'h0);

        // second write restarts the countdown
        b_wr(2'd1, 8'h34);
        tick();
        b_wr(2'd1, 8'h56);
        tick();
        b_wr_en = 1'b0;
        tick(); tick();
        chk("restart_e3_q", {8'h0, b_q}, 32'h005A_0012);
        tick();
        chk("restart_e4_q",    {8'h0, b_q}, 32'h005A_5612);
        chk("restart_e4_done", {31'h0, b_done}, 32'h1);

        // freeze pauses the countdown for two edges
        b_wr(2'd0, 8'h77);
        tick();
        b_wr_en = 1'b0;
        tick();
        b_freeze = 1'b1;
        tick(); tick();
        b_freeze = 1'b0;
        chk("pause_e3_q",     {8'h0, b_q}, 32'h005A_5612);
        chk("pause_e3_dirty", {29'h0, b_dirty}, 32'h1);
        tick();
        chk("pause_e4_q", {8'h0, b_q}, 32'h005A_5612);
        tick();
        chk("pause_e5_q",    {8'h0, b_q}, 32'h005A_5677);
        chk("pause_e5_done", {31'h0, b_done}, 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
